// File: rtl/pwr_pkg.sv
// Shared state encoding and default widths for the protected 5 V rail sequencer.
package pwr_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int MA_W_DEF  = 12;

    typedef enum logic [2:0] {
        OFF        = 3'd0,
        SOFTSTART  = 3'd1,
        ON         = 3'd2,
        TRIP       = 3'd3,
        RETRY_WAIT = 3'd4,
        LOCKOUT    = 3'd5
    } pwr_state_t;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/pwr_rr_arbiter.sv
// Round-robin pick over an eligible mask; combinational one-hot pick, pointer moves past the taken index.
// No backpressure: the pointer only advances when the caller asserts take.
module pwr_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] eligible,
    input  logic         take,
    output logic [N-1:0] pick,
    output logic         pick_vld
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] idx;
    int               pos;

    // ptr is the first index considered, i.e. one past the last taken index
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = '0;
        pos      = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PTR_W'(pos);
            if (!pick_vld && eligible[idx]) begin
                pick[idx] = 1'b1;
                pick_vld  = 1'b1;
                pick_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take && pick_vld) begin
            ptr <= (pick_idx == PTR_W'(N - 1)) ? '0 : pick_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/pwr_load_sequencer.sv
// Soft-start, load-budget sharing and overcurrent trip/retry/lockout for the 5 V rail; all outputs registered.
// Optional peak_ma tracker built when PWR_PEAK_HOLD_EN is defined; otherwise peak_ma reads 0.
module pwr_load_sequencer
    import pwr_pkg::*;
#(
    parameter int N_REQ         = N_REQ_DEF,
    parameter int MA_W          = MA_W_DEF,
    parameter int BUDGET_MA     = 500,
    parameter int BASE_MA       = 120,
    parameter int SOFTSTART_CYC = 16,
    parameter int TRIP_CYC      = 8,
    parameter int RETRY_CYC     = 64,
    parameter int MAX_RETRY     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    polarity_ok,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*MA_W-1:0]   req_ma,
    input  logic [MA_W-1:0]         meas_ma,
    output logic                    pwr_en,
    output logic [N_REQ-1:0]        gnt,
    output logic [MA_W+1:0]         used_ma,
    output pwr_state_t              state,
    output logic [1:0]              trip_cnt,
    output logic                    lockout,
    output logic [MA_W-1:0]         peak_ma,
    input  logic                    peak_clr
);

    localparam int UW      = MA_W + 2;
    localparam int SW      = UW + 1;
    localparam int CNT_MAX = (SOFTSTART_CYC > RETRY_CYC) ? SOFTSTART_CYC : RETRY_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_W   = $clog2(TRIP_CYC + 1);

    logic [CNT_W-1:0] cyc_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [MA_W-1:0]  lat_ma [N_REQ];

    logic             rail_ok;
    logic             over;
    logic             trip_now;
    logic             take;
    logic             pick_vld;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] rel_mask;
    logic [N_REQ-1:0] gnt_next;
    logic [UW-1:0]    add_ma;
    logic [UW-1:0]    sub_ma;
    logic [UW-1:0]    used_next;

    assign rail_ok  = en && polarity_ok;
    assign over     = meas_ma > MA_W'(BUDGET_MA);
    assign trip_now = over && (run_cnt == RUN_W'(TRIP_CYC - 1));

    // Fit check uses the pre-release sum so a same-cycle release never lets a grant overshoot
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && !gnt[i] &&
                ({1'b0, used_ma} + SW'(req_ma[i*MA_W +: MA_W]) <= SW'(BUDGET_MA))) begin
                eligible[i] = 1'b1;
            end
        end
    end

    pwr_rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .take     (take),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    assign take     = (state == ON) && rail_ok && !trip_now && pick_vld;
    assign rel_mask = gnt & ~req;
    assign gnt_next = (gnt & req) | (take ? pick : '0);

    always_comb begin
        add_ma = '0;
        sub_ma = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (take && pick[i]) begin
                add_ma = add_ma + UW'(req_ma[i*MA_W +: MA_W]);
            end
            if (rel_mask[i]) begin
                sub_ma = sub_ma + UW'(lat_ma[i]);
            end
        end
    end

    assign used_next = used_ma + add_ma - sub_ma;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OFF;
            pwr_en   <= 1'b0;
            gnt      <= '0;
            used_ma  <= '0;
            trip_cnt <= 2'd0;
            lockout  <= 1'b0;
            cyc_cnt  <= '0;
            run_cnt  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                lat_ma[i] <= '0;
            end
        end else begin
            case (state)
                OFF: begin
                    if (rail_ok) begin
                        state   <= SOFTSTART;
                        pwr_en  <= 1'b1;
                        used_ma <= UW'(BASE_MA);
                        cyc_cnt <= '0;
                    end
                end

                SOFTSTART: begin
                    if (!rail_ok) begin
                        state   <= OFF;
                        pwr_en  <= 1'b0;
                        gnt     <= '0;
                        used_ma <= '0;
                        cyc_cnt <= '0;
                    end else if (cyc_cnt == CNT_W'(SOFTSTART_CYC - 1)) begin
                        state   <= ON;
                        run_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                ON: begin
                    // Losing enable or polarity wins over a trip in the same cycle
                    if (!rail_ok) begin
                        state   <= OFF;
                        pwr_en  <= 1'b0;
                        gnt     <= '0;
                        used_ma <= '0;
                        run_cnt <= '0;
                    end else if (trip_now) begin
                        state    <= TRIP;
                        pwr_en   <= 1'b0;
                        gnt      <= '0;
                        used_ma  <= '0;
                        run_cnt  <= '0;
                        trip_cnt <= sat_inc2(trip_cnt);
                    end else begin
                        run_cnt <= over ? run_cnt + RUN_W'(1) : '0;
                        gnt     <= gnt_next;
                        used_ma <= used_next;
                        for (int i = 0; i < N_REQ; i++) begin
                            if (take && pick[i]) begin
                                lat_ma[i] <= req_ma[i*MA_W +: MA_W];
                            end
                        end
                    end
                end

                TRIP: begin
                    if (trip_cnt >= 2'(MAX_RETRY)) begin
                        state   <= LOCKOUT;
                        lockout <= 1'b1;
                    end else begin
                        state   <= RETRY_WAIT;
                        cyc_cnt <= '0;
                    end
                end

                RETRY_WAIT: begin
                    if (cyc_cnt == CNT_W'(RETRY_CYC - 1)) begin
                        cyc_cnt <= '0;
                        if (rail_ok) begin
                            state   <= SOFTSTART;
                            pwr_en  <= 1'b1;
                            used_ma <= UW'(BASE_MA);
                        end else begin
                            state <= OFF;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                LOCKOUT: begin
                    if (!en) begin
                        state    <= OFF;
                        lockout  <= 1'b0;
                        trip_cnt <= 2'd0;
                    end
                end

                default: begin
                    state   <= OFF;
                    pwr_en  <= 1'b0;
                    gnt     <= '0;
                    used_ma <= '0;
                    lockout <= 1'b0;
                    cyc_cnt <= '0;
                    run_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PWR_PEAK_HOLD_EN
    // Clear takes priority over a same-cycle sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_ma <= '0;
        end else if (peak_clr) begin
            peak_ma <= '0;
        end else if (pwr_en && (meas_ma > peak_ma)) begin
            peak_ma <= meas_ma;
        end
    end
`else
    logic peak_clr_unused;
    assign peak_clr_unused = peak_clr;
    assign peak_ma         = '0;
`endif

endmodule

// File: tb/tb_pwr_load_sequencer.sv
// Bench for pwr_load_sequencer: vector table, directed corner sequences, then random traffic vs a spec-level model.
module tb_pwr_load_sequencer;
    import pwr_pkg::*;

    localparam int N      = 4;
    localparam int MW     = 12;
    localparam int BUDGET = 500;
    localparam int BASE   = 120;
    localparam int SS_CYC = 16;
    localparam int TR_CYC = 8;
    localparam int RT_CYC = 64;
    localparam int MAXR   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            polarity_ok;
    logic [N-1:0]    req;
    logic [N*MW-1:0] req_ma;
    logic [MW-1:0]   meas_ma;
    logic            peak_clr;
    logic            pwr_en;
    logic [N-1:0]    gnt;
    logic [MW+1:0]   used_ma;
    pwr_state_t      state;
    logic [1:0]      trip_cnt;
    logic            lockout;
    logic [MW-1:0]   peak_ma;

    int errors = 0;
    int checks = 0;

    pwr_load_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .polarity_ok (polarity_ok),
        .req         (req),
        .req_ma      (req_ma),
        .meas_ma     (meas_ma),
        .pwr_en      (pwr_en),
        .gnt         (gnt),
        .used_ma     (used_ma),
        .state       (state),
        .trip_cnt    (trip_cnt),
        .lockout     (lockout),
        .peak_ma     (peak_ma),
        .peak_clr    (peak_clr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    pwr_state_t m_st;
    int         m_timer;
    int         m_run;
    int         m_trips;
    int         m_last;
    int         m_peak;
    int         m_ma [N];
    bit         m_g  [N];

    function automatic int req_ma_of(input int i);
        return int'(req_ma[i*MW +: MW]);
    endfunction

    function automatic int m_sum();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) if (m_g[i]) s += m_ma[i];
        return s;
    endfunction

    task automatic m_drop_all();
        for (int i = 0; i < N; i++) m_g[i] = 1'b0;
        m_run = 0;
    endtask

    task automatic model_reset();
        m_st    = OFF;
        m_timer = 0;
        m_run   = 0;
        m_trips = 0;
        m_last  = N - 1;
        m_peak  = 0;
        for (int i = 0; i < N; i++) begin
            m_g[i]  = 1'b0;
            m_ma[i] = 0;
        end
    endtask

    task automatic model_step();
        bit rail;
        bit on_before;
        int used;
        int pick;
        int idx;
        rail      = en && polarity_ok;
        on_before = (m_st == SOFTSTART) || (m_st == ON);
        if (peak_clr) m_peak = 0;
        else if (on_before && int'(meas_ma) > m_peak) m_peak = int'(meas_ma);
        case (m_st)
            OFF: if (rail) begin
                m_st = SOFTSTART; m_timer = SS_CYC;
            end
            SOFTSTART: begin
                if (!rail) begin
                    m_st = OFF; m_drop_all();
                end else begin
                    m_timer--;
                    if (m_timer == 0) begin m_st = ON; m_run = 0; end
                end
            end
            ON: begin
                if (!rail) begin
                    m_st = OFF; m_drop_all();
                end else begin
                    m_run = (int'(meas_ma) > BUDGET) ? m_run + 1 : 0;
                    if (m_run >= TR_CYC) begin
                        m_st = TRIP; m_drop_all();
                        m_trips = (m_trips < 3) ? m_trips + 1 : 3;
                    end else begin
                        used = BASE + m_sum();
                        pick = -1;
                        for (int k = 1; k <= N; k++) begin
                            idx = (m_last + k) % N;
                            if (pick < 0 && req[idx] && !m_g[idx] && used + req_ma_of(idx) <= BUDGET) pick = idx;
                        end
                        for (int i = 0; i < N; i++) if (m_g[i] && !req[i]) m_g[i] = 1'b0;
                        if (pick >= 0) begin
                            m_g[pick] = 1'b1; m_ma[pick] = req_ma_of(pick); m_last = pick;
                        end
                    end
                end
            end
            TRIP: begin
                if (m_trips >= MAXR) m_st = LOCKOUT;
                else begin m_st = RETRY_WAIT; m_timer = RT_CYC; end
            end
            RETRY_WAIT: begin
                m_timer--;
                if (m_timer == 0) begin
                    if (rail) begin m_st = SOFTSTART; m_timer = SS_CYC; end
                    else m_st = OFF;
                end
            end
            LOCKOUT: if (!en) begin m_st = OFF; m_trips = 0; end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_model();
        bit       pe;
        logic [N-1:0] g;
        pe = (m_st == SOFTSTART) || (m_st == ON);
        for (int i = 0; i < N; i++) g[i] = m_g[i];
        chk("m_state", 32'(state), 32'(m_st));
        chk("m_pwr_en", 32'(pwr_en), 32'(pe));
        chk("m_gnt", 32'(gnt), 32'(g));
        chk("m_used_ma", 32'(used_ma), pe ? 32'(BASE + m_sum()) : 32'd0);
        chk("m_trip_cnt", 32'(trip_cnt), 32'(m_trips));
        chk("m_lockout", 32'(lockout), 32'(m_st == LOCKOUT));
`ifdef PWR_PEAK_HOLD_EN
        chk("m_peak_ma", 32'(peak_ma), 32'(m_peak));
`else
        chk("m_peak_ma", 32'(peak_ma), 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ma(input int i, input int v);
        req_ma[i*MW +: MW] = MW'(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(OFF));
        chk({tag, "_pwr_en"}, 32'(pwr_en), 32'd0);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_used"}, 32'(used_ma), 32'd0);
        chk({tag, "_trip"}, 32'(trip_cnt), 32'd0);
        chk({tag, "_lockout"}, 32'(lockout), 32'd0);
        chk({tag, "_peak"}, 32'(peak_ma), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         en;
        bit         pol;
        logic [3:0] req;
        int         ma0;
        int         ma1;
        int         cycles;
        pwr_state_t st;
        bit         pe;
        logic [3:0] g;
        int         used;
    } vec_t;

    vec_t tbl [14];

    int burst_left;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 4'b0000,   0,   0,  3, OFF,       1'b0, 4'b0000,   0};
        tbl[1]  = '{1'b1, 1'b0, 4'b0000,   0,   0,  2, OFF,       1'b0, 4'b0000,   0};
        tbl[2]  = '{1'b1, 1'b1, 4'b0000,   0,   0,  1, SOFTSTART, 1'b1, 4'b0000, 120};
        tbl[3]  = '{1'b1, 1'b1, 4'b0000,   0,   0, 15, SOFTSTART, 1'b1, 4'b0000, 120};
        tbl[4]  = '{1'b1, 1'b1, 4'b0000,   0,   0,  1, ON,        1'b1, 4'b0000, 120};
        tbl[5]  = '{1'b1, 1'b1, 4'b0011, 300, 200,  1, ON,        1'b1, 4'b0001, 420};
        tbl[6]  = '{1'b1, 1'b1, 4'b0011, 300, 200,  2, ON,        1'b1, 4'b0001, 420};
        tbl[7]  = '{1'b1, 1'b1, 4'b0010, 300, 200,  1, ON,        1'b1, 4'b0000, 120};
        tbl[8]  = '{1'b1, 1'b1, 4'b0010, 300, 200,  1, ON,        1'b1, 4'b0010, 320};
        tbl[9]  = '{1'b1, 1'b1, 4'b0000, 300, 200,  1, ON,        1'b1, 4'b0000, 120};
        tbl[10] = '{1'b1, 1'b1, 4'b0011, 381, 380,  1, ON,        1'b1, 4'b0010, 500};
        tbl[11] = '{1'b1, 1'b1, 4'b0011, 381, 380,  2, ON,        1'b1, 4'b0010, 500};
        tbl[12] = '{1'b1, 1'b1, 4'b0000, 381, 380,  1, ON,        1'b1, 4'b0000, 120};
        tbl[13] = '{1'b0, 1'b1, 4'b0000,   0,   0,  1, OFF,       1'b0, 4'b0000,   0};

        rst_n = 1'b0; en = 1'b0; polarity_ok = 1'b1; req = '0; req_ma = '0;
        meas_ma = '0; peak_clr = 1'b0; burst_left = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            en = tbl[r].en; polarity_ok = tbl[r].pol; req = tbl[r].req;
            set_ma(0, tbl[r].ma0); set_ma(1, tbl[r].ma1);
            run(tbl[r].cycles);
            chk($sformatf("v%0d_state", r), 32'(state), 32'(tbl[r].st));
            chk($sformatf("v%0d_pwr_en", r), 32'(pwr_en), 32'(tbl[r].pe));
            chk($sformatf("v%0d_gnt", r), 32'(gnt), 32'(tbl[r].g));
            chk($sformatf("v%0d_used", r), 32'(used_ma), 32'(tbl[r].used));
        end

        // trip after 8 over-budget cycles, retry, and a broken run that must not trip
        en = 1'b1; polarity_ok = 1'b1; req = '0; req_ma = '0;
        run(17);
        chk("trip_pre_on", 32'(state), 32'(ON));
        meas_ma = 12'd2000; run(7);
        chk("trip_7_on", 32'(state), 32'(ON));
        run(1);
        chk("trip_state", 32'(state), 32'(TRIP));
        chk("trip_pwr_en", 32'(pwr_en), 32'd0);
        chk("trip_cnt1", 32'(trip_cnt), 32'd1);
        run(1);
        chk("retry_state", 32'(state), 32'(RETRY_WAIT));
        meas_ma = '0; run(63);
        chk("retry_63", 32'(state), 32'(RETRY_WAIT));
        run(1);
        chk("retry_done", 32'(state), 32'(SOFTSTART));
        run(16);
        meas_ma = 12'd2000; run(7);
        meas_ma = 12'd480;  run(1);
        meas_ma = 12'd2000; run(7);
        chk("notrip_state", 32'(state), 32'(ON));
        chk("notrip_cnt", 32'(trip_cnt), 32'd1);

        // sustained overcurrent runs out of retries
        run(1);
        chk("trip2_cnt", 32'(trip_cnt), 32'd2);
        run(89);
        chk("trip3_state", 32'(state), 32'(TRIP));
        chk("trip3_cnt", 32'(trip_cnt), 32'd3);
        run(1);
        chk("lock_state", 32'(state), 32'(LOCKOUT));
        chk("lock_flag", 32'(lockout), 32'd1);
        meas_ma = '0; run(5);
        chk("lock_hold", 32'(lockout), 32'd1);
        en = 1'b0; run(1);
        chk("unlock_state", 32'(state), 32'(OFF));
        chk("unlock_cnt", 32'(trip_cnt), 32'd0);

        // polarity loss drops grants; enable loss overrides a trip
        en = 1'b1; run(17);
        req = 4'b0001; set_ma(0, 100); run(1);
        chk("pol_gnt", 32'(gnt), 32'd1);
        chk("pol_used", 32'(used_ma), 32'd220);
        polarity_ok = 1'b0; run(1);
        chk("pol_state", 32'(state), 32'(OFF));
        chk("pol_gnt_off", 32'(gnt), 32'd0);
        chk("pol_used_off", 32'(used_ma), 32'd0);
        req = '0; polarity_ok = 1'b1; run(17);
        meas_ma = 12'd2000; run(7);
        en = 1'b0; run(1);
        chk("ovr_state", 32'(state), 32'(OFF));
        chk("ovr_cnt", 32'(trip_cnt), 32'd0);
        meas_ma = '0;

        // peak hold
        en = 1'b1; run(17);
        peak_clr = 1'b1; run(1); peak_clr = 1'b0;
        meas_ma = 12'd120; run(1);
        meas_ma = 12'd480; run(1);
        meas_ma = 12'd200; run(1);
`ifdef PWR_PEAK_HOLD_EN
        chk("peak_480", 32'(peak_ma), 32'd480);
`else
        chk("peak_480", 32'(peak_ma), 32'd0);
`endif
        peak_clr = 1'b1; meas_ma = 12'd300; run(1);
        chk("peak_clr", 32'(peak_ma), 32'd0);
        peak_clr = 1'b0; meas_ma = '0;

        // asynchronous reset mid-operation
        req = 4'b0001; set_ma(0, 50); run(2);
        #2; rst_n = 1'b0; #1;
        check_reset_outputs("arst");
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        req = '0;

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            en          = ($urandom % 100) != 0;
            polarity_ok = ($urandom % 200) != 0;
            peak_clr    = ($urandom % 50) == 0;
            for (int i = 0; i < N; i++) begin
                if (($urandom % 8) == 0) req[i] = ~req[i];
                set_ma(i, $urandom_range(0, 250));
            end
            if (burst_left > 0) begin
                meas_ma = MW'(501 + $urandom % 1500);
                burst_left--;
            end else begin
                meas_ma = MW'($urandom % 501);
                if (($urandom % 40) == 0) burst_left = $urandom_range(3, 12);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
